// File: rtl/xnor3_parity_sched.sv
// ---------------------------------------------------------------------------
// xnor3_parity_sched
//
// Round-robin scheduler sharing a single XNOR3 parity fold engine among NREQ
// requesters. The granted requester's WIDTH-bit word is captured into a shift
// register and folded two bits per cycle through one 3-input XNOR stage fed
// by a running accumulator. The word's XNOR reduction (~^word) is returned
// with a one-cycle DONE pulse and the serviced requester index.
//
// Optional feature:
//   XNOR3_PARITY_SCHED_STALL_EN - adds input HOLD; while HOLD=1 in FOLD the
//   shift register, accumulator and fold counter freeze.
//
// Ports:
//   CLK      in   rising-edge clock
//   RST      in   asynchronous active-high reset
//   HOLD     in   fold stall (only with XNOR3_PARITY_SCHED_STALL_EN)
//   REQ      in   [NREQ]        per-requester level request
//   DATA     in   [NREQ*WIDTH]  requester i word at DATA[i*WIDTH +: WIDTH]
//   GNT      out  [NREQ]        one-hot grant, held for the service interval
//   BUSY     out  high while not IDLE
//   DONE     out  one-cycle completion pulse
//   DONE_ID  out  [IDW]         serviced requester index, valid with DONE
//   ZN       out  XNOR reduction of the captured word, valid with DONE
//
// States:
//   ST_IDLE | waiting for a request, arbitrates round-robin from ptr
//   ST_FOLD | folding two bits per cycle through the XNOR3 stage
//   ST_DONE | DONE pulse cycle; releases grant and advances ptr
// ---------------------------------------------------------------------------
module xnor3_parity_sched #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                    CLK,
  input  logic                    RST,
`ifdef XNOR3_PARITY_SCHED_STALL_EN
  input  logic                    HOLD,
`endif
  input  logic [NREQ-1:0]         REQ,
  input  logic [NREQ*WIDTH-1:0]   DATA,
  output logic [NREQ-1:0]         GNT,
  output logic                    BUSY,
  output logic                    DONE,
  output logic [IDW-1:0]          DONE_ID,
  output logic                    ZN
);

  localparam int HALF = WIDTH / 2;
  localparam int CW   = $clog2(HALF + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FOLD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_q,   state_d;
  logic [NREQ-1:0]    gnt_q,     gnt_d;
  logic               busy_q,    busy_d;
  logic               done_q,    done_d;
  logic [IDW-1:0]     done_id_q, done_id_d;
  logic               zn_q,      zn_d;
  logic [IDW-1:0]     ptr_q,     ptr_d;
  logic [IDW-1:0]     win_q,     win_d;
  logic [WIDTH-1:0]   sr_q,      sr_d;
  logic               acc_q,     acc_d;
  logic [CW-1:0]      cnt_q,     cnt_d;

  // -------------------------------------------------------------------------
  // Round-robin arbiter: first set REQ bit at or above ptr, wrapping.
  // -------------------------------------------------------------------------
  logic               arb_found;
  logic [IDW-1:0]     arb_win;

  always_comb begin
    int idx;
    idx       = 0;
    arb_found = 1'b0;
    arb_win   = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      if (!arb_found && REQ[idx]) begin
        arb_found = 1'b1;
        arb_win   = IDW'(idx);
      end
    end
  end

  // -------------------------------------------------------------------------
  // XNOR3 fold stage. Its output is ~(acc ^ b1 ^ b0); the accumulator keeps
  // the running XOR, so it loads the inverted stage output. On the final
  // fold edge the stage output itself is the word's XNOR reduction.
  // -------------------------------------------------------------------------
  logic xnor3_zn;
  logic acc_fold;

  assign xnor3_zn = ~(acc_q ^ sr_q[1] ^ sr_q[0]);
  assign acc_fold = ~xnor3_zn;

  logic fold_adv;
`ifdef XNOR3_PARITY_SCHED_STALL_EN
  assign fold_adv = ~HOLD;
`else
  assign fold_adv = 1'b1;
`endif

  logic last_fold;
  assign last_fold = (cnt_q == CW'(HALF - 1));

  // -------------------------------------------------------------------------
  // Next-state / output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    busy_d    = busy_q;
    done_d    = done_q;
    done_id_d = done_id_q;
    zn_d      = zn_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    sr_d      = sr_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (arb_found) begin
          state_d = ST_FOLD;
          gnt_d   = NREQ'(1) << arb_win;
          busy_d  = 1'b1;
          win_d   = arb_win;
          // DATA is sampled only here; later changes do not affect the result.
          sr_d    = DATA[arb_win*WIDTH +: WIDTH];
          acc_d   = 1'b0;
          cnt_d   = '0;
        end
      end

      ST_FOLD: begin
        if (fold_adv) begin
          sr_d  = sr_q >> 2;
          acc_d = acc_fold;
          cnt_d = cnt_q + CW'(1);
          if (last_fold) begin
            zn_d      = xnor3_zn;
            done_d    = 1'b1;
            done_id_d = win_q;
            state_d   = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        done_d  = 1'b0;
        gnt_d   = '0;
        busy_d  = 1'b0;
        // The just-served requester becomes lowest priority.
        ptr_d   = (win_q == IDW'(NREQ - 1)) ? '0 : (win_q + IDW'(1));
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= '0;
      zn_q      <= 1'b0;
      ptr_q     <= '0;
      win_q     <= '0;
      sr_q      <= '0;
      acc_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      zn_q      <= zn_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      sr_q      <= sr_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
    end
  end

  assign GNT     = gnt_q;
  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign DONE_ID = done_id_q;
  assign ZN      = zn_q;

endmodule

// File: tb/tb_xnor3_parity_sched.sv
// ---------------------------------------------------------------------------
// tb_xnor3_parity_sched
//
// Directed bench for xnor3_parity_sched (NREQ=4, WIDTH=16). Inputs change on
// the falling edge, outputs are sampled on the falling edge. Expected values
// are hand-computed constants. With XNOR3_PARITY_SCHED_STALL_EN defined the
// HOLD port is driven and a stall case is added.
// ---------------------------------------------------------------------------
module tb_xnor3_parity_sched;

  localparam int NREQ  = 4;
  localparam int WIDTH = 16;
  localparam int IDW   = 2;

  logic                    clk;
  logic                    rst;
  logic [NREQ-1:0]         req;
  logic [NREQ*WIDTH-1:0]   data;
  logic [NREQ-1:0]         gnt;
  logic                    busy;
  logic                    done;
  logic [IDW-1:0]          done_id;
  logic                    zn;
`ifdef XNOR3_PARITY_SCHED_STALL_EN
  logic                    hold;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  xnor3_parity_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .CLK     (clk),
    .RST     (rst),
`ifdef XNOR3_PARITY_SCHED_STALL_EN
    .HOLD    (hold),
`endif
    .REQ     (req),
    .DATA    (data),
    .GNT     (gnt),
    .BUSY    (busy),
    .DONE    (done),
    .DONE_ID (done_id),
    .ZN      (zn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called on the falling edge right after the grant edge. Counts falling
  // edges until DONE (bounded) and the cycles GNT equals exp_gnt.
  task automatic wait_done(input logic [NREQ-1:0] exp_gnt, input int hs, input int hl,
                           output int n_done, output int n_gnt);
    n_gnt  = (gnt == exp_gnt) ? 1 : 0;
    n_done = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
`ifdef XNOR3_PARITY_SCHED_STALL_EN
      if (hl > 0 && n == hs) hold = 1'b1;
      if (hl > 0 && n == hs + hl) hold = 1'b0;
`endif
      if (gnt == exp_gnt) n_gnt++;
      if (done) begin
        n_done = n;
        break;
      end
    end
  endtask

  // Single-requester service. With scramble set, REQ drops and the word
  // changes to zero right after the grant; the result must not change.
  task automatic serve(input string tag, input int id, input logic [WIDTH-1:0] w,
                       input logic exp_zn, input bit scramble,
                       input int hs, input int hl, input int exp_n);
    logic [NREQ-1:0] g;
    int nd, ng;
    g = NREQ'(1) << id;
    data[id*WIDTH +: WIDTH] = w;
    req = g;
    @(negedge clk);
    chk({tag, "_gnt"}, 32'(gnt), 32'(g));
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    req = '0;
    if (scramble) data[id*WIDTH +: WIDTH] = '0;
    wait_done(g, hs, hl, nd, ng);
    chk({tag, "_done_lat"}, 32'(nd), 32'(exp_n));
    chk({tag, "_gnt_cycles"}, 32'(ng), 32'(exp_n + 1));
    chk({tag, "_done_id"}, 32'(done_id), 32'(id));
    chk({tag, "_zn"}, 32'(zn), 32'(exp_zn));
    @(negedge clk);
    chk({tag, "_done_clr"}, 32'(done), 32'd0);
    chk({tag, "_gnt_clr"}, 32'(gnt), 32'd0);
    chk({tag, "_busy_clr"}, 32'(busy), 32'd0);
    chk({tag, "_zn_hold"}, 32'(zn), 32'(exp_zn));
  endtask

  initial begin
    int n;
    int seen;
    logic [IDW-1:0] exp_ids [7];
    exp_ids = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd3, 2'd0};

    rst  = 1'b1;
    req  = 4'b1111;
    data = '0;
`ifdef XNOR3_PARITY_SCHED_STALL_EN
    hold = 1'b0;
`endif

    // Reset with all requests asserted.
    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_zn", 32'(zn), 32'd0);
    chk("rst_done_id", 32'(done_id), 32'd0);

    // First grant after release goes to requester 0; word 0x0001 -> ZN=0.
    data[0*WIDTH +: WIDTH] = 16'h0001;
    rst = 1'b0;
    req = 4'b1111;
    @(negedge clk);
    chk("first_gnt", 32'(gnt), 32'b0001);
    req = '0;
    begin
      int nd, ng;
      wait_done(4'b0001, 0, 0, nd, ng);
      chk("first_done_lat", 32'(nd), 32'd8);
      chk("first_done_id", 32'(done_id), 32'd0);
      chk("first_zn", 32'(zn), 32'd0);
    end
    @(negedge clk);
    chk("first_busy_clr", 32'(busy), 32'd0);

    // Single requests on requester 1.
    serve("single_0001", 1, 16'h0001, 1'b0, 1'b0, 0, 0, 8);
    serve("single_0003", 1, 16'h0003, 1'b1, 1'b0, 0, 0, 8);
    serve("single_ffff", 1, 16'hFFFF, 1'b1, 1'b0, 0, 0, 8);
    serve("single_a5c3", 2, 16'hA5C3, 1'b1, 1'b0, 0, 0, 8);
    serve("single_8000", 3, 16'h8000, 1'b0, 1'b0, 0, 0, 8);

    // Round robin from a fresh pointer: 0,1,2,3,0 then REQ=1001 with ptr=1.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req = 4'b1111;
    for (int k = 0; k < 7; k++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!done && n < 40);
      chk($sformatf("rr_spacing_%0d", k), 32'(n), (k == 0) ? 32'd9 : 32'd10);
      chk($sformatf("rr_id_%0d", k), 32'(done_id), 32'(exp_ids[k]));
      if (k == 4) req = 4'b1001;
      if (k == 6) req = 4'b0000;
    end
    @(negedge clk);
    chk("rr_idle", 32'(busy), 32'd0);

    // Withdraw: REQ and word drop after grant; 0x0007 -> ZN=0 (0x0000 would give 1).
    serve("withdraw", 2, 16'h0007, 1'b0, 1'b1, 0, 0, 8);

    // Abort with RST at t0+4.
    data[1*WIDTH +: WIDTH] = 16'h0001;
    req = 4'b0010;
    @(negedge clk);
    chk("abort_gnt", 32'(gnt), 32'b0010);
    req = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_gnt_clr", 32'(gnt), 32'd0);
    chk("abort_busy_clr", 32'(busy), 32'd0);
    chk("abort_done_id", 32'(done_id), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("abort_no_done", 32'(seen), 32'd0);
    serve("after_abort", 3, 16'h00F0, 1'b1, 1'b0, 0, 0, 8);

`ifdef XNOR3_PARITY_SCHED_STALL_EN
    // HOLD for 3 cycles during FOLD extends latency to 11; result unchanged.
    serve("stall", 1, 16'h0003, 1'b1, 1'b0, 2, 3, 11);
    serve("stall_odd", 2, 16'h0001, 1'b0, 1'b0, 4, 3, 11);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/xnor3_parity_sched.md
# xnor3_parity_sched

Round-robin scheduler that shares one XNOR3-based parity fold engine among NREQ requesters in the gf180mcu 9-track digital library. Each granted requester's WIDTH-bit word is captured and reduced two bits per cycle through a single 3-input XNOR stage fed by a running accumulator. The block returns the word's XNOR-reduction (ZN = ~^word) with a one-cycle completion pulse. It is used wherever several low-rate agents need parity and a dedicated tree per agent costs too much area.

## Interface
- NREQ, 4, number of requesters (≥2)
- WIDTH, 16, word width in bits (even, ≥2)

- CLK  input  1  rising-edge clock
- RST  input  1  asynchronous active-high reset
- REQ  input  NREQ  per-requester request, level
- DATA  input  NREQ*WIDTH  requester i word at DATA[i*WIDTH +: WIDTH]
- GNT  output  NREQ  one-hot grant, high for the whole service interval
- BUSY  output  1  high when state ≠ IDLE
- DONE  output  1  one-cycle completion pulse
- DONE_ID  output  $clog2(NREQ)  index of the serviced requester, valid with DONE
- ZN  output  1  XNOR reduction of the captured word, valid with DONE

## Operation
- States: IDLE, FOLD, DONE.
- IDLE: on an edge with REQ≠0, pick the winner round-robin.
  - Start from pointer PTR, take the first set REQ bit at or above PTR, wrapping.
  - Set GNT to the winner, capture its DATA slice into the shift register, clear ACC and CNT, go to FOLD.
- FOLD: each edge consumes SR[1:0] through the XNOR3 stage, shifts SR right by 2 and increments CNT.
  - ACC holds the running XOR of the consumed bits.
  - On the edge where CNT reaches WIDTH/2, load ZN = ~ACC_final, set DONE=1, load DONE_ID = winner, go to DONE.
- DONE: next edge clears DONE and GNT, sets PTR = (winner+1) mod NREQ, and goes to IDLE.
- DATA is sampled only at the grant edge. Later DATA changes are ignored.
- REQ falling after grant has no effect: the service completes and DONE still pulses.
- REQ falling before grant means no service.
- A requester still asserting REQ in IDLE after its DONE is re-arbitrated at lowest priority.
- ZN and DONE_ID hold their last values until the next DONE.
- Reset values: GNT=0, BUSY=0, DONE=0, DONE_ID=0, ZN=0, PTR=0, state IDLE, SR/ACC/CNT=0.
- RST mid-operation aborts immediately. No DONE is produced for the aborted word.

## Timing
- t0 = the IDLE edge that grants. GNT, BUSY and the SR load are visible after t0.
- FOLD spans edges t0+1 … t0+WIDTH/2. DONE is high after edge t0+WIDTH/2 for exactly one cycle.
- GNT is high for WIDTH/2+1 cycles.
- BUSY falls after edge t0+WIDTH/2+1.
- The earliest next grant is at edge t0+WIDTH/2+2.
- Throughput: one word per WIDTH/2+2 cycles.
- All outputs are registered. There are no combinational REQ→GNT paths.
- RST is asynchronous assert. Deassertion must be synchronized externally to CLK.

## Configuration
- XNOR3_PARITY_SCHED_STALL_EN defined:
  - Adds input HOLD (1 bit).
  - While HOLD=1 in FOLD, SR, ACC and CNT freeze.
  - Each HOLD cycle extends latency by one cycle.
  - HOLD is ignored in IDLE and DONE.
- Not defined: no HOLD port exists, and FOLD always advances.

## Test plan
- Reset: assert RST with REQ=4'b1111 → GNT=0, BUSY=0, DONE=0, ZN=0, DONE_ID=0. After release, the first grant goes to requester 0.
- Single request: REQ=4'b0010, DATA[1]=16'h0001 → GNT=4'b0010 for 9 cycles, DONE at t0+8, DONE_ID=1, ZN=0. Repeat with 16'h0003 → ZN=1. Repeat with 16'hFFFF → ZN=1.
- Round-robin: REQ=4'b1111 held → DONE_ID sequence 0,1,2,3,0, one DONE every 10 cycles. REQ=4'b1001 with PTR=1 → 3 served before 0.
- Withdraw: REQ[2] dropped one cycle after grant, DATA changed to 16'h0000 → DONE still pulses, DONE_ID=2, and ZN is computed from the captured word.
- Abort: RST pulsed at t0+4 → GNT=0 and BUSY=0 immediately, no DONE. The next request is serviced with full 10-cycle spacing.
- Stall (STALL_EN): HOLD=1 for 3 cycles during FOLD → DONE at t0+11, ZN unchanged versus the no-stall result.
